// File: rtl/mms_ptw_pkg.sv
// Shared definitions for the Sv32 page-table walker: PTE layout, walk depth
// and the walker state encoding.
package mms_ptw_pkg;

    localparam int unsigned PTE_WD     = 32;
    localparam int unsigned PTW_LEVELS = 2;

    localparam int unsigned PTE_V       = 0;
    localparam int unsigned PTE_R       = 1;
    localparam int unsigned PTE_W       = 2;
    localparam int unsigned PTE_X       = 3;
    localparam int unsigned PTE_U       = 4;
    localparam int unsigned PTE_G       = 5;
    localparam int unsigned PTE_A       = 6;
    localparam int unsigned PTE_D       = 7;
    localparam int unsigned PTE_PPN_LSB = 10;
    localparam int unsigned PTE_PPN_MSB = 31;

    // Bare mode grants everything except the global bit.
    localparam logic [7:0] BARE_FLAGS = 8'hDF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_L1_REQ,
        S_L1_WAIT,
        S_L0_REQ,
        S_L0_WAIT,
        S_RESP,
        S_FAULT
    } ptw_state_e;

endpackage

// File: rtl/mms_ptw_pte_chk.sv
// Combinational Sv32 PTE checker: classifies a fetched PTE as invalid, leaf
// or non-leaf and decides whether the walk must fault at the given level.
module mms_ptw_pte_chk
    import mms_ptw_pkg::*;
(
    input  logic [PTE_WD-1:0] i_pte,
    input  logic              i_level,
    input  logic              i_store,
    output logic              o_invalid,
    output logic              o_leaf,
    output logic              o_fault
);

    logic w_invalid;
    logic w_leaf;
    logic w_misaligned;
    logic w_leaf_fault;
    logic w_unused_bits;

    assign w_invalid    = ~i_pte[PTE_V] | (~i_pte[PTE_R] & i_pte[PTE_W]);
    assign w_leaf       = i_pte[PTE_R] | i_pte[PTE_X];
    // A superpage leaf must have PPN0 clear.
    assign w_misaligned = i_level & (i_pte[PTE_PPN_LSB+9:PTE_PPN_LSB] != '0);
    assign w_leaf_fault = ~i_pte[PTE_A] | (i_store & ~i_pte[PTE_D]) | w_misaligned;

    assign w_unused_bits = ^{i_pte[PTE_PPN_MSB:PTE_PPN_LSB+10], i_pte[9:8],
                             i_pte[PTE_G], i_pte[PTE_U]};

    assign o_invalid = w_invalid;
    assign o_leaf    = w_leaf;
    assign o_fault   = w_invalid | (w_leaf ? w_leaf_fault : ~i_level);

endmodule

// File: rtl/mms_ptw.sv
// Sv32 two-level hardware page-table walker: serves TLB misses through a
// single-outstanding PTE read port and returns a refill or page-fault pulse.
module mms_ptw
    import mms_ptw_pkg::*;
#(
    parameter int unsigned VADDR_WD = 32,
    parameter int unsigned PADDR_WD = 34,
    parameter int unsigned PPN_WD   = 22,
    parameter int unsigned ASID_WD  = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 satp_mode_i,
    input  logic [ASID_WD-1:0]   satp_asid_i,
    input  logic [PPN_WD-1:0]    satp_ppn_i,
    input  logic                 flush_i,
    input  logic                 miss_valid_i,
    output logic                 miss_ready_o,
    input  logic [VADDR_WD-13:0] miss_vpn_i,
    input  logic                 miss_store_i,
    output logic                 mem_req_valid_o,
    input  logic                 mem_req_ready_i,
    output logic [PADDR_WD-1:0]  mem_req_paddr_o,
    input  logic                 mem_resp_valid_i,
    input  logic [PTE_WD-1:0]    mem_resp_data_i,
    output logic                 refill_valid_o,
    output logic [VADDR_WD-13:0] refill_vpn_o,
    output logic [PPN_WD-1:0]    refill_ppn_o,
    output logic [7:0]           refill_flags_o,
    output logic                 refill_level_o,
    output logic [ASID_WD-1:0]   refill_asid_o,
    output logic                 fault_valid_o
);

    localparam int unsigned VPN_WD = VADDR_WD - 12;

    ptw_state_e          r_state;
    logic                r_drop;
    logic                r_store;
    logic                r_miss_ready;
    logic                r_mem_req_valid;
    logic [PADDR_WD-1:0] r_mem_req_paddr;
    logic                r_refill_valid;
    logic                r_fault_valid;
    logic [VPN_WD-1:0]   r_vpn;
    logic [PPN_WD-1:0]   r_ppn;
    logic [7:0]          r_flags;
    logic                r_level;
    logic [ASID_WD-1:0]  r_asid;

    logic w_pte_invalid;
    logic w_pte_leaf;
    logic w_pte_fault;
    logic w_at_l1;
    logic w_dropping;

    function automatic logic [PADDR_WD-1:0] pte_addr(input logic [PPN_WD-1:0] ppn,
                                                     input logic [9:0]        idx);
        return PADDR_WD'({ppn, 12'b0}) + PADDR_WD'({idx, 2'b0});
    endfunction

    assign w_at_l1    = (r_state == S_L1_WAIT);
    assign w_dropping = r_drop | flush_i;

    mms_ptw_pte_chk u_pte_chk (
        .i_pte     (mem_resp_data_i),
        .i_level   (w_at_l1),
        .i_store   (r_store),
        .o_invalid (w_pte_invalid),
        .o_leaf    (w_pte_leaf),
        .o_fault   (w_pte_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= S_IDLE;
            r_drop          <= 1'b0;
            r_store         <= 1'b0;
            r_miss_ready    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_paddr <= '0;
            r_refill_valid  <= 1'b0;
            r_fault_valid   <= 1'b0;
            r_vpn           <= '0;
            r_ppn           <= '0;
            r_flags         <= '0;
            r_level         <= 1'b0;
            r_asid          <= '0;
        end else begin
            r_refill_valid <= 1'b0;
            r_fault_valid  <= 1'b0;
            if (r_state != S_IDLE && flush_i) begin
                r_drop <= 1'b1;
            end

            unique case (r_state)
                S_IDLE: begin
                    r_drop       <= 1'b0;
                    r_miss_ready <= 1'b1;
                    if (miss_valid_i && r_miss_ready) begin
                        r_miss_ready <= 1'b0;
                        r_vpn        <= miss_vpn_i;
                        r_store      <= miss_store_i;
                        r_asid       <= satp_asid_i;
                        if (!satp_mode_i) begin
                            r_state        <= S_RESP;
                            r_refill_valid <= 1'b1;
                            r_ppn          <= PPN_WD'(miss_vpn_i);
                            r_flags        <= BARE_FLAGS;
                            r_level        <= 1'b0;
                        end else begin
                            r_state         <= S_L1_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_paddr <= pte_addr(satp_ppn_i, miss_vpn_i[VPN_WD-1:10]);
                        end
                    end
                end

                S_L1_REQ, S_L0_REQ: begin
                    if (mem_req_ready_i) begin
                        r_mem_req_valid <= 1'b0;
                        r_state         <= (r_state == S_L1_REQ) ? S_L1_WAIT : S_L0_WAIT;
                    end
                end

                S_L1_WAIT, S_L0_WAIT: begin
                    // A dropped walk retires straight to IDLE once its response is consumed.
                    if (mem_resp_valid_i) begin
                        if (w_dropping) begin
                            r_state      <= S_IDLE;
                            r_miss_ready <= 1'b1;
                        end else if (w_pte_fault) begin
                            r_state       <= S_FAULT;
                            r_fault_valid <= 1'b1;
                        end else if (!w_pte_leaf && !w_pte_invalid) begin
                            r_state         <= S_L0_REQ;
                            r_mem_req_valid <= 1'b1;
                            r_mem_req_paddr <= pte_addr(mem_resp_data_i[PTE_PPN_MSB:PTE_PPN_LSB],
                                                        r_vpn[9:0]);
                        end else begin
                            r_state        <= S_RESP;
                            r_refill_valid <= 1'b1;
                            r_ppn          <= mem_resp_data_i[PTE_PPN_MSB:PTE_PPN_LSB];
                            r_flags        <= mem_resp_data_i[7:0];
                            r_level        <= w_at_l1;
                        end
                    end
                end

                S_RESP, S_FAULT: begin
                    r_state      <= S_IDLE;
                    r_miss_ready <= 1'b1;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign miss_ready_o    = r_miss_ready;
    assign mem_req_valid_o = r_mem_req_valid;
    assign mem_req_paddr_o = r_mem_req_paddr;
    assign refill_valid_o  = r_refill_valid;
    assign refill_vpn_o    = r_vpn;
    assign refill_ppn_o    = r_ppn;
    assign refill_flags_o  = r_flags;
    assign refill_level_o  = r_level;
    assign refill_asid_o   = r_asid;
    assign fault_valid_o   = r_fault_valid;

endmodule

// File: tb/tb_mms_ptw.sv
// Directed self-checking bench for mms_ptw: 4 KiB and superpage walks, fault
// cases, flush discard, memory backpressure, bare mode and reset.
module tb_mms_ptw;

    logic        clk = 1'b0;
    logic        rst;
    logic        satp_mode_i;
    logic [8:0]  satp_asid_i;
    logic [21:0] satp_ppn_i;
    logic        flush_i;
    logic        miss_valid_i;
    logic        miss_ready_o;
    logic [19:0] miss_vpn_i;
    logic        miss_store_i;
    logic        mem_req_valid_o;
    logic        mem_req_ready_i;
    logic [33:0] mem_req_paddr_o;
    logic        mem_resp_valid_i;
    logic [31:0] mem_resp_data_i;
    logic        refill_valid_o;
    logic [19:0] refill_vpn_o;
    logic [21:0] refill_ppn_o;
    logic [7:0]  refill_flags_o;
    logic        refill_level_o;
    logic [8:0]  refill_asid_o;
    logic        fault_valid_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mms_ptw #(.VADDR_WD(32), .PADDR_WD(34), .PPN_WD(22), .ASID_WD(9)) dut (
        .clk              (clk),
        .rst              (rst),
        .satp_mode_i      (satp_mode_i),
        .satp_asid_i      (satp_asid_i),
        .satp_ppn_i       (satp_ppn_i),
        .flush_i          (flush_i),
        .miss_valid_i     (miss_valid_i),
        .miss_ready_o     (miss_ready_o),
        .miss_vpn_i       (miss_vpn_i),
        .miss_store_i     (miss_store_i),
        .mem_req_valid_o  (mem_req_valid_o),
        .mem_req_ready_i  (mem_req_ready_i),
        .mem_req_paddr_o  (mem_req_paddr_o),
        .mem_resp_valid_i (mem_resp_valid_i),
        .mem_resp_data_i  (mem_resp_data_i),
        .refill_valid_o   (refill_valid_o),
        .refill_vpn_o     (refill_vpn_o),
        .refill_ppn_o     (refill_ppn_o),
        .refill_flags_o   (refill_flags_o),
        .refill_level_o   (refill_level_o),
        .refill_asid_o    (refill_asid_o),
        .fault_valid_o    (fault_valid_o)
    );

    // Inputs are driven and outputs sampled 1 ns after each rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Handshake a miss; returns positioned in cycle T1.
    task automatic start_miss(input logic [19:0] vpn, input logic st);
        int n = 0;
        while (!miss_ready_o && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (miss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL miss_ready_timeout: got %b expected 1", miss_ready_o);
        end
        miss_vpn_i   = vpn;
        miss_store_i = st;
        miss_valid_i = 1'b1;
        tick();
        miss_valid_i = 1'b0;
    endtask

    // Zero-wait single-level walk; captures the outputs at T3 and ends at T4.
    task automatic l1_walk(input logic [19:0] vpn, input logic st, input logic [31:0] pte,
                           output logic rv, output logic fv, output logic [21:0] ppn,
                           output logic [7:0] flags, output logic lvl);
        start_miss(vpn, st);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = pte;
        tick();
        mem_resp_valid_i = 1'b0;
        rv    = refill_valid_o;
        fv    = fault_valid_o;
        ppn   = refill_ppn_o;
        flags = refill_flags_o;
        lvl   = refill_level_o;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        checks++;
        if ({miss_ready_o, mem_req_valid_o, refill_valid_o, fault_valid_o} !== 4'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 0000",
                     {miss_ready_o, mem_req_valid_o, refill_valid_o, fault_valid_o});
        end
        checks++;
        if ({mem_req_paddr_o, refill_ppn_o, refill_flags_o, refill_asid_o} !== '0) begin
            errors++;
            $display("FAIL reset_data: got paddr %h ppn %h flags %h expected 0",
                     mem_req_paddr_o, refill_ppn_o, refill_flags_o);
        end
        rst = 1'b0;
        tick();
        checks++;
        if (miss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", miss_ready_o);
        end
    endtask

    task automatic test_walk_4k();
        satp_mode_i = 1'b1;
        satp_asid_i = 9'h05A;
        satp_ppn_i  = 22'h00100;
        start_miss(20'h12345, 1'b0);
        checks++;
        if ({mem_req_valid_o, mem_req_paddr_o} !== {1'b1, 34'h0_0010_0120}) begin
            errors++;
            $display("FAIL 4k_req1: got v=%b %h expected v=1 000100120", mem_req_valid_o, mem_req_paddr_o);
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h00080001;
        tick();
        mem_resp_valid_i = 1'b0;
        checks++;
        if ({mem_req_valid_o, mem_req_paddr_o, refill_valid_o} !== {1'b1, 34'h0_0020_0D14, 1'b0}) begin
            errors++;
            $display("FAIL 4k_req2: got v=%b %h rv=%b expected v=1 000200d14 rv=0",
                     mem_req_valid_o, mem_req_paddr_o, refill_valid_o);
        end
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h02AF34C7;
        tick();
        mem_resp_valid_i = 1'b0;
        checks++;
        if ({refill_valid_o, fault_valid_o} !== 2'b10) begin
            errors++;
            $display("FAIL 4k_pulse_T5: got rv=%b fv=%b expected rv=1 fv=0", refill_valid_o, fault_valid_o);
        end
        checks++;
        if ({refill_ppn_o, refill_flags_o, refill_level_o} !== {22'h0ABCD, 8'hC7, 1'b0}) begin
            errors++;
            $display("FAIL 4k_data: got ppn %h flags %h lvl %b expected 00abcd c7 0",
                     refill_ppn_o, refill_flags_o, refill_level_o);
        end
        checks++;
        if ({refill_vpn_o, refill_asid_o} !== {20'h12345, 9'h05A}) begin
            errors++;
            $display("FAIL 4k_tag: got vpn %h asid %h expected 12345 05a", refill_vpn_o, refill_asid_o);
        end
        tick();
        checks++;
        if ({refill_valid_o, miss_ready_o} !== 2'b01) begin
            errors++;
            $display("FAIL 4k_after: got rv=%b ready=%b expected rv=0 ready=1", refill_valid_o, miss_ready_o);
        end
    endtask

    task automatic test_superpage();
        logic rv, fv, lvl;
        logic [21:0] ppn;
        logic [7:0]  fl;
        l1_walk(20'h12345, 1'b0, 32'h001000CB, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv, ppn, fl, lvl} !== {1'b1, 1'b0, 22'h000400, 8'hCB, 1'b1}) begin
            errors++;
            $display("FAIL superpage: got rv=%b fv=%b ppn %h flags %h lvl %b expected 1 0 000400 cb 1",
                     rv, fv, ppn, fl, lvl);
        end
    endtask

    task automatic test_faults();
        logic rv, fv, lvl;
        logic [21:0] ppn;
        logic [7:0]  fl;
        l1_walk(20'h12345, 1'b0, 32'h001004CB, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv} !== 2'b01) begin
            errors++;
            $display("FAIL misaligned: got rv=%b fv=%b expected rv=0 fv=1", rv, fv);
        end
        l1_walk(20'h12345, 1'b1, 32'h00100047, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv} !== 2'b01) begin
            errors++;
            $display("FAIL store_clean: got rv=%b fv=%b expected rv=0 fv=1", rv, fv);
        end
        l1_walk(20'h12345, 1'b0, 32'h00100047, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv, fl} !== {2'b10, 8'h47}) begin
            errors++;
            $display("FAIL load_clean: got rv=%b fv=%b flags %h expected 1 0 47", rv, fv, fl);
        end
        l1_walk(20'h12345, 1'b0, 32'h001000C5, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv} !== 2'b01) begin
            errors++;
            $display("FAIL w_without_r: got rv=%b fv=%b expected rv=0 fv=1", rv, fv);
        end
        l1_walk(20'h12345, 1'b0, 32'h001000CA, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv} !== 2'b01) begin
            errors++;
            $display("FAIL not_valid: got rv=%b fv=%b expected rv=0 fv=1", rv, fv);
        end
    endtask

    task automatic test_flush();
        logic seen = 1'b0;
        logic rv, fv, lvl;
        logic [21:0] ppn;
        logic [7:0]  fl;
        start_miss(20'h12345, 1'b0);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h00080001;
        tick();
        mem_resp_valid_i = 1'b0;
        mem_req_ready_i  = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        flush_i         = 1'b1;
        tick();
        flush_i = 1'b0;
        seen |= refill_valid_o | fault_valid_o;
        tick();
        seen |= refill_valid_o | fault_valid_o;
        tick();
        seen |= refill_valid_o | fault_valid_o;
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h02AF34C7;
        tick();
        mem_resp_valid_i = 1'b0;
        checks++;
        if (miss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_ready: got %b expected 1", miss_ready_o);
        end
        for (int i = 0; i < 3; i++) begin
            seen |= refill_valid_o | fault_valid_o;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL flush_discard: got pulse=%b expected 0", seen);
        end
        l1_walk(20'h00ABC, 1'b0, 32'h001000CB, rv, fv, ppn, fl, lvl);
        checks++;
        if ({rv, fv} !== 2'b10) begin
            errors++;
            $display("FAIL post_flush_walk: got rv=%b fv=%b expected rv=1 fv=0", rv, fv);
        end
    endtask

    task automatic test_backpressure();
        int reqs = 0;
        int stable_bad = 0;
        start_miss(20'h12345, 1'b0);
        for (int i = 0; i < 4; i++) begin
            if (mem_req_valid_o !== 1'b1 || mem_req_paddr_o !== 34'h0_0010_0120) stable_bad++;
            if (mem_req_valid_o && mem_req_ready_i) reqs++;
            tick();
        end
        checks++;
        if (stable_bad !== 0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles expected 0", stable_bad);
        end
        mem_req_ready_i = 1'b1;
        if (mem_req_valid_o && mem_req_ready_i) reqs++;
        tick();
        mem_req_ready_i = 1'b0;
        if (mem_req_valid_o && mem_req_ready_i) reqs++;
        checks++;
        if (mem_req_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bp_drop_valid: got %b expected 0", mem_req_valid_o);
        end
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h001000CB;
        tick();
        mem_resp_valid_i = 1'b0;
        checks++;
        if (reqs !== 1) begin
            errors++;
            $display("FAIL bp_req_count: got %0d expected 1", reqs);
        end
        checks++;
        if ({refill_valid_o, refill_ppn_o} !== {1'b1, 22'h000400}) begin
            errors++;
            $display("FAIL bp_refill: got rv=%b ppn %h expected 1 000400", refill_valid_o, refill_ppn_o);
        end
        tick();
    endtask

    task automatic test_bare();
        satp_mode_i = 1'b0;
        satp_asid_i = 9'h1C3;
        start_miss(20'hFFFFF, 1'b1);
        checks++;
        if ({refill_valid_o, mem_req_valid_o, refill_ppn_o, refill_flags_o, refill_level_o}
            !== {1'b1, 1'b0, 22'h0FFFFF, 8'hDF, 1'b0}) begin
            errors++;
            $display("FAIL bare_refill: got rv=%b mv=%b ppn %h flags %h lvl %b expected 1 0 0fffff df 0",
                     refill_valid_o, mem_req_valid_o, refill_ppn_o, refill_flags_o, refill_level_o);
        end
        checks++;
        if (refill_asid_o !== 9'h1C3) begin
            errors++;
            $display("FAIL bare_asid: got %h expected 1c3", refill_asid_o);
        end
        tick();
        checks++;
        if (refill_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL bare_one_cycle: got %b expected 0", refill_valid_o);
        end
        satp_mode_i = 1'b1;
    endtask

    task automatic test_reset_midwalk();
        start_miss(20'h12345, 1'b0);
        mem_req_ready_i = 1'b1;
        tick();
        mem_req_ready_i = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({miss_ready_o, mem_req_valid_o, refill_valid_o, fault_valid_o} !== 4'b0) begin
            errors++;
            $display("FAIL midwalk_reset: got %b expected 0000",
                     {miss_ready_o, mem_req_valid_o, refill_valid_o, fault_valid_o});
        end
        tick();
        mem_resp_valid_i = 1'b1;
        mem_resp_data_i  = 32'h001000CB;
        tick();
        mem_resp_valid_i = 1'b0;
        tick();
        checks++;
        if ({refill_valid_o, fault_valid_o, miss_ready_o} !== 3'b001) begin
            errors++;
            $display("FAIL stale_resp: got rv=%b fv=%b ready=%b expected 0 0 1",
                     refill_valid_o, fault_valid_o, miss_ready_o);
        end
    endtask

    initial begin
        rst              = 1'b1;
        satp_mode_i      = 1'b1;
        satp_asid_i      = '0;
        satp_ppn_i       = 22'h00100;
        flush_i          = 1'b0;
        miss_valid_i     = 1'b0;
        miss_vpn_i       = '0;
        miss_store_i     = 1'b0;
        mem_req_ready_i  = 1'b0;
        mem_resp_valid_i = 1'b0;
        mem_resp_data_i  = '0;

        test_reset();
        test_walk_4k();
        test_superpage();
        test_faults();
        test_flush();
        test_backpressure();
        test_bare();
        test_reset_midwalk();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
